// File: rtl/multi_clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package multi_clk_div_pkg;

  localparam int unsigned MAX_CH            = 16;
  localparam int unsigned DEFAULT_DIV_100HZ = 500_000;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned res;
    res = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        res = res + 1;
        v   = v >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter with active/pending divisor
// registers so period changes land on a toggle boundary.
module clk_div_channel
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_100HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_div,
  output logic             tick
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             wrap_c;

  // Next-state: sync realigns, act==0 stalls, otherwise count and wrap.
  always_comb begin
    count_d    = count_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_div_d  = clk_div_q;
    tick_d     = 1'b0;
    wrap_c     = en && (act_q != '0) && (count_q == act_q - CNT_W'(1));

    if (sync) begin
      count_d   = '0;
      clk_div_d = 1'b0;
      if (wr) begin
        act_d = wr_val;
      end else if (pend_vld_q) begin
        act_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (act_q == '0) begin
      count_d   = '0;
      clk_div_d = 1'b0;
      if (wr) begin
        act_d      = wr_val;
        pend_vld_d = 1'b0;
      end
    end else if (wrap_c) begin
      count_d   = '0;
      clk_div_d = ~clk_div_q;
      tick_d    = 1'b1;
      if (wr) begin
        act_d = wr_val;
      end else if (pend_vld_q) begin
        act_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else begin
      if (en) begin
        count_d = count_q + CNT_W'(1);
      end
      if (wr) begin
        pend_d     = wr_val;
        pend_vld_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      act_q      <= CNT_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_div_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_div_q  <= clk_div_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_div = clk_div_q;
  assign tick    = tick_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider: write decode and sync fan-out.
// Optional MULTI_CLK_DIV_SYNC_EN adds a 'sync' input that phase-aligns all
// channels and applies pending divisors.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_100HZ,
  localparam int unsigned CH_W       = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MULTI_CLK_DIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr_sel_c;
  logic              sync_c;

`ifdef MULTI_CLK_DIV_SYNC_EN
  assign sync_c = sync;
`else
  assign sync_c = 1'b0;
`endif

  // Decode the write strobe to one channel; out-of-range indices match nothing.
  always_comb begin
    wr_sel_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (div_wr && (div_ch == CH_W'(i))) begin
        wr_sel_c[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync_c),
      .wr      (wr_sel_c[g]),
      .wr_val  (div_val),
      .clk_div (clk_div[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div (NUM_CH=4, DEFAULT_DIV=5).
module tb_multi_clk_div;

  localparam int unsigned NCH = 4;
  localparam int unsigned DEF = 5;

  logic       clk;
  logic       rst;
  logic       sync;
  logic [3:0] en;
  logic       div_wr;
  logic [1:0] div_ch;
  logic [7:0] div_val;
  logic [3:0] clk_div;
  logic [3:0] tick;

  int n_cmp;
  int n_bad;

  // Reference model: cycles left until the next toggle per channel.
  int unsigned m_act  [NCH];
  int unsigned m_left [NCH];
  int unsigned m_pend [NCH];
  bit [3:0]    m_pvld;
  bit [3:0]    m_clk;
  bit [3:0]    m_tick;
  logic [7:0]  exp_q[$];

  multi_clk_div #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(5)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef MULTI_CLK_DIV_SYNC_EN
    .sync    (sync),
`endif
    .en      (en),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .clk_div (clk_div),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one edge using the inputs now driven; queue result.
  task automatic step_model();
    bit w;
    for (int i = 0; i < int'(NCH); i++) begin
      if (rst) begin
        m_act[i] = DEF; m_left[i] = DEF; m_pend[i] = 0;
        m_pvld[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        w = div_wr && (int'(div_ch) == i);
        m_tick[i] = 0;
        if (sync) begin
          m_clk[i] = 0;
          if (w) m_act[i] = 32'(div_val);
          else if (m_pvld[i]) m_act[i] = m_pend[i];
          m_pvld[i] = 0;
          m_left[i] = m_act[i];
        end else if (m_act[i] == 0) begin
          m_clk[i] = 0;
          if (w) begin
            m_act[i] = 32'(div_val); m_left[i] = 32'(div_val); m_pvld[i] = 0;
          end
        end else if (en[i] && m_left[i] == 1) begin
          m_clk[i] = ~m_clk[i];
          m_tick[i] = 1;
          if (w) m_act[i] = 32'(div_val);
          else if (m_pvld[i]) m_act[i] = m_pend[i];
          m_pvld[i] = 0;
          m_left[i] = m_act[i];
        end else begin
          if (en[i]) m_left[i] = m_left[i] - 1;
          if (w) begin m_pend[i] = 32'(div_val); m_pvld[i] = 1; end
        end
      end
    end
    exp_q.push_back({m_clk, m_tick});
  endtask

  // One clock: push expectation, wait to the sampling edge, pop expectation.
  task automatic sb_next(output logic [7:0] e);
    step_model();
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1; sync = 0; en = 4'h0; div_wr = 0; div_ch = 0; div_val = 0;
    for (int k = 0; k < 3; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_reset t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
    end
    n_cmp++;
    if (clk_div !== 4'h0 || tick !== 4'h0) begin
      n_bad++; $display("FAIL reset_state got clk_div=%h tick=%h exp 0/0", clk_div, tick);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    int ticks0, first0, phase_bad;
    ticks0 = 0; first0 = -1; phase_bad = 0;
    rst = 0; en = 4'hF;
    for (int k = 1; k <= 40; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_basic t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      if (tick[0] === 1'b1) begin ticks0++; if (first0 < 0) first0 = k; end
      if (!(clk_div === 4'h0 || clk_div === 4'hF) || !(tick === 4'h0 || tick === 4'hF))
        phase_bad++;
    end
    n_cmp++;
    if (first0 != 5) begin n_bad++; $display("FAIL basic_first_tick got=%0d exp=5", first0); end
    n_cmp++;
    if (ticks0 != 8) begin n_bad++; $display("FAIL basic_tick_count got=%0d exp=8", ticks0); end
    n_cmp++;
    if (phase_bad != 0) begin n_bad++; $display("FAIL basic_in_phase got=%0d exp=0", phase_bad); end
  endtask

  task automatic test_div_change();
    logic [7:0] e;
    logic [19:0] got2, exp2, got0, exp0;
    got2 = '0; exp2 = '0; got0 = '0; exp0 = '0;
    for (int k = 5; k <= 20; k += 3) exp2[k-1] = 1'b1;
    for (int k = 5; k <= 20; k += 5) exp0[k-1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      div_wr = (k == 3); div_ch = 2'd2; div_val = 8'd3;
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_div_change t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      got2[k-1] = tick[2]; got0[k-1] = tick[0];
    end
    div_wr = 0;
    n_cmp++;
    if (got2 !== exp2) begin n_bad++; $display("FAIL div_change_ch2 got=%b exp=%b", got2, exp2); end
    n_cmp++;
    if (got0 !== exp0) begin n_bad++; $display("FAIL div_change_ch0 got=%b exp=%b", got0, exp0); end
  endtask

  task automatic test_last_write();
    logic [7:0] e;
    logic [19:0] got1, exp1;
    got1 = '0; exp1 = '0;
    for (int k = 5; k <= 20; k += 2) exp1[k-1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      div_wr = (k == 2 || k == 3); div_ch = 2'd1; div_val = (k == 2) ? 8'd7 : 8'd2;
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_last_write t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      got1[k-1] = tick[1];
    end
    div_wr = 0;
    n_cmp++;
    if (got1 !== exp1) begin n_bad++; $display("FAIL last_write_ch1 got=%b exp=%b", got1, exp1); end
  endtask

  task automatic test_enable();
    logic [7:0] e;
    bit found;
    bit held;
    int frz_bad;
    logic [5:0] got, expv;
    found = 0; frz_bad = 0; got = '0; expv = 6'b000010;
    for (int k = 0; k < 20 && !found; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_enable_wait t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      if (tick[0] === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL enable_wait_tick0 got=0 exp=1"); end
    for (int k = 0; k < 3; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_enable_pre t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
    end
    held = m_clk[0];
    en = 4'hE;
    for (int k = 0; k < 20; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_enable_off t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      if (clk_div[0] !== held || tick[0] !== 1'b0) frz_bad++;
    end
    n_cmp++;
    if (frz_bad != 0) begin n_bad++; $display("FAIL enable_frozen got=%0d exp=0", frz_bad); end
    en = 4'hF;
    for (int k = 0; k < 6; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_enable_on t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      got[k] = tick[0];
    end
    n_cmp++;
    if (got !== expv) begin n_bad++; $display("FAIL enable_resume got=%b exp=%b", got, expv); end
  endtask

  task automatic test_stall();
    logic [7:0] e;
    int stall_bad;
    logic [9:0] got, expv;
    stall_bad = 0; got = '0; expv = 10'b1111111110;
    for (int k = 1; k <= 25; k++) begin
      div_wr = (k == 1); div_ch = 2'd3; div_val = 8'd0;
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_stall t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      if (k > 15 && (clk_div[3] !== 1'b0 || tick[3] !== 1'b0)) stall_bad++;
    end
    n_cmp++;
    if (stall_bad != 0) begin n_bad++; $display("FAIL stall_held got=%0d exp=0", stall_bad); end
    for (int k = 1; k <= 10; k++) begin
      div_wr = (k == 1); div_ch = 2'd3; div_val = 8'd1;
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_unstall t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      got[k-1] = tick[3];
    end
    div_wr = 0;
    n_cmp++;
    if (got !== expv) begin n_bad++; $display("FAIL unstall_ch3 got=%b exp=%b", got, expv); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] e;
    logic [11:0] got, expv;
    got = '0; expv = 12'b0010_0001_0000;
    div_wr = 1; div_ch = 2'd0; div_val = 8'd9;
    sb_next(e); n_cmp++;
    if ({clk_div, tick} !== e) begin
      n_bad++; $display("FAIL sb_rst_mid_wr t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
    end
    div_wr = 0; rst = 1;
    sb_next(e); n_cmp++;
    if ({clk_div, tick} !== e) begin
      n_bad++; $display("FAIL sb_rst_mid t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
    end
    rst = 0;
    for (int k = 0; k < 12; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_rst_release t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      got[k] = tick[0];
    end
    n_cmp++;
    if (got !== expv) begin n_bad++; $display("FAIL rst_mid_ch0 got=%b exp=%b", got, expv); end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int k = 0; k < 150; k++) begin
      en      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      div_wr  = ($urandom_range(0, 5) == 0);
      div_ch  = 2'($urandom_range(0, 3));
      div_val = 8'($urandom_range(0, 6));
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_random t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
    end
    div_wr = 0; en = 4'hF;
  endtask

`ifdef MULTI_CLK_DIV_SYNC_EN
  task automatic test_sync();
    logic [7:0] e;
    int first [NCH];
    rst = 1;
    sb_next(e);
    rst = 0; en = 4'hF;
    for (int k = 0; k < 4; k++) begin
      div_wr = 1; div_ch = 2'(k); div_val = 8'(k + 3);
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_sync_wr t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
    end
    div_wr = 0; sync = 1;
    sb_next(e);
    sync = 0;
    n_cmp++;
    if (clk_div !== 4'h0 || tick !== 4'h0 || {clk_div, tick} !== e) begin
      n_bad++; $display("FAIL sync_clear got=%h exp=%h", {clk_div, tick}, e);
    end
    for (int i = 0; i < int'(NCH); i++) first[i] = -1;
    for (int k = 1; k <= 12; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_sync_run t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
      for (int i = 0; i < int'(NCH); i++)
        if (tick[i] === 1'b1 && first[i] < 0) first[i] = k;
    end
    for (int i = 0; i < int'(NCH); i++) begin
      n_cmp++;
      if (first[i] != i + 3) begin
        n_bad++; $display("FAIL sync_first_tick ch%0d got=%0d exp=%0d", i, first[i], i + 3);
      end
    end
    rst = 1; sync = 1;
    sb_next(e);
    rst = 0; sync = 0;
    n_cmp++;
    if (clk_div !== 4'h0 || tick !== 4'h0 || {clk_div, tick} !== e) begin
      n_bad++; $display("FAIL sync_rst_priority got=%h exp=%h", {clk_div, tick}, e);
    end
    for (int k = 0; k < 12; k++) begin
      sb_next(e); n_cmp++;
      if ({clk_div, tick} !== e) begin
        n_bad++; $display("FAIL sb_sync_post t=%0t got=%h exp=%h", $time, {clk_div, tick}, e);
      end
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_basic();
    test_div_change();
    test_last_write();
    test_enable();
    test_stall();
    test_rst_mid();
    test_random();
`ifdef MULTI_CLK_DIV_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 27, counter/divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 500_000, half-period in input cycles loaded at reset into every channel (100 Hz from 100 MHz).
REQ-004 SHALL have port clk  input  1  system clock (100 MHz nominal).
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port div_wr  input  1  divisor write strobe, one-cycle.
REQ-008 SHALL have port div_ch  input  clog2(NUM_CH) (min 1)  target channel of write.
REQ-009 SHALL have port div_val  input  CNT_W  new half-period in cycles.
REQ-010 SHALL have port clk_div  output  NUM_CH  registered divided clock per channel, 50% duty.
REQ-011 SHALL have port tick  output  NUM_CH  registered one-cycle pulse on every clk_div toggle.

Function
REQ-012 Each channel SHALL hold count (CNT_W), active divisor act, pending divisor pend, and pend_vld flag.
REQ-013 With en[i]=1 and act>0, count SHALL increment each cycle; when count==act-1 ("wrap") count SHALL return to 0, clk_div[i] SHALL toggle and tick[i] SHALL be 1 for exactly that next cycle.
REQ-014 Output period SHALL be 2*act cycles; act=1 SHALL yield clk/2 with tick high every cycle.
REQ-015 With en[i]=0, count, clk_div[i] SHALL hold their values and tick[i] SHALL be 0; re-enable SHALL resume from the held count.
REQ-016 div_wr with div_ch<NUM_CH SHALL set pend=div_val, pend_vld=1 for that channel; div_ch>=NUM_CH SHALL be ignored.
REQ-017 On wrap with pend_vld=1, act SHALL load pend and pend_vld SHALL clear, so periods change glitch-free on a toggle boundary.
REQ-018 div_wr coinciding with a wrap on the same channel SHALL apply div_val directly to act at that wrap and leave pend_vld=0.
REQ-019 A second div_wr before the wrap SHALL overwrite pend (last write wins).
REQ-020 If act==0 the channel SHALL be stalled: count=0, clk_div[i]=0, tick[i]=0; any div_wr to a stalled channel SHALL load act immediately and restart count at 0.
REQ-021 Counter arithmetic SHALL be unsigned CNT_W; count SHALL never exceed act-1.

Reset
REQ-022 While rst=1 at a clk edge: count=0, clk_div=0, tick=0, act=DEFAULT_DIV, pend_vld=0, for all channels.
REQ-023 rst mid-period SHALL discard any pending divisor; first toggle after release SHALL occur DEFAULT_DIV cycles after the first non-reset edge with en=1.

Configuration
REQ-024 Macro MULTI_CLK_DIV_SYNC_EN SHALL add input port sync (1 bit); sync=1 SHALL set every channel count=0, clk_div=0, tick=0 and apply any pending divisor, phase-aligning all channels; rst SHALL take priority over sync.
REQ-025 Without MULTI_CLK_DIV_SYNC_EN the sync port and logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-026 Package multi_clk_div_pkg SHALL hold MAX_CH=16, DEFAULT_DIV_100HZ=500_000, and the clog2 function.
REQ-027 Per-channel logic SHALL be sub-module clk_div_channel, instantiated NUM_CH times in a generate loop; top SHALL contain only write decode and sync fan-out.

Verification
REQ-028 Reset, NUM_CH=4, DEFAULT_DIV=5, en=4'hF -> each clk_div toggles every 5 cycles (period 10), tick pulses every 5 cycles, all channels in phase.
REQ-029 Write div_ch=2, div_val=3 mid-period -> ch2 completes current 5-cycle half-period, then toggles every 3 cycles; other channels unchanged.
REQ-030 Write div_val=7 then div_val=2 to ch1 before wrap -> ch1 applies 2 at next wrap; 7 never observed.
REQ-031 en[0]=0 for 20 cycles at count=3 -> clk_div[0] frozen, tick[0]=0; after re-enable first toggle after 2 more cycles.
REQ-032 Write div_val=0 to ch3 -> after next wrap clk_div[3]=0 held; write div_val=1 -> ch3 toggles every cycle starting immediately.
REQ-033 With MULTI_CLK_DIV_SYNC_EN, divisors 3,4,5,6 running, pulse sync -> all clk_div=0 next cycle, then toggles at 3,4,5,6 cycles respectively; rst and sync together -> reset values.
